// File: rtl/operand_fetch.sv
// operand_fetch: register file with write-back bypass feeding a one-deep valid/ready operand register for the ALU
module operand_fetch #(
  parameter int Address_Width = 5,
  parameter int Data_Width    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Address_Width-1:0] rs1,
  input  logic [Address_Width-1:0] rs2,
  input  logic [Address_Width-1:0] rd,
  input  logic [Data_Width-1:0]    imm,
  input  logic                     ALUsrc,
  input  logic                     ALU_ctrl_in,
  input  logic                     RegWrite_in,
  input  logic                     wb_en,
  input  logic [Address_Width-1:0] wb_addr,
  input  logic [Data_Width-1:0]    wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Data_Width-1:0]    op1,
  output logic [Data_Width-1:0]    op2,
  output logic                     ALU_ctrl,
  output logic [Address_Width-1:0] rd_q,
  output logic                     RegWrite_q,
  output logic [Data_Width-1:0]    a0
);
  logic [Data_Width-1:0] regs [2**Address_Width];
  logic [Data_Width-1:0] rd1, rd2, op2_next;
  logic                  cap;
  // reads see a same-cycle write-back; x0 is forced to zero
  always_comb begin
    rd1      = (rs1 == '0) ? '0 : (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
    rd2      = (rs2 == '0) ? '0 : (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
    op2_next = ALUsrc ? imm : rd2;
    in_ready = !out_valid || out_ready;
    cap      = in_valid && in_ready;
    a0       = regs[10];
  end
  // register file: cleared by reset, x0 never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2**Address_Width; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end
  // operand bundle: load on capture, drop valid on consume, hold while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      op1        <= '0;
      op2        <= '0;
      ALU_ctrl   <= 1'b0;
      rd_q       <= '0;
      RegWrite_q <= 1'b0;
    end else if (cap) begin
      out_valid  <= 1'b1;
      op1        <= rd1;
      op2        <= op2_next;
      ALU_ctrl   <= ALU_ctrl_in;
      rd_q       <= rd;
      RegWrite_q <= RegWrite_in;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed table, handshake corner sequences and randomized run against a behavioural model
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ALUsrc, ALU_ctrl_in, RegWrite_in, wb_en;
  logic        out_valid, out_ready, ALU_ctrl, RegWrite_q;
  logic [4:0]  rs1, rs2, rd, wb_addr, rd_q;
  logic [31:0] imm, wb_data, op1, op2, a0;
  int          errors = 0, checks = 0;

  logic [31:0] m_regs [32];
  logic        m_valid, m_ctrl, m_regw;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_rd;

  typedef struct {
    logic rst, in_valid, out_ready, alusrc, ctrl, wb_en;
    logic [4:0] rs1, rs2, wb_addr;
    logic [31:0] imm, wb_data;
    logic exp_valid, exp_ctrl;
    logic [31:0] exp_op1, exp_op2, exp_a0;
  } vec_t;
  vec_t vecs [8];

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ALUsrc(ALUsrc),
    .ALU_ctrl_in(ALU_ctrl_in), .RegWrite_in(RegWrite_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
    .ALU_ctrl(ALU_ctrl), .rd_q(rd_q), .RegWrite_q(RegWrite_q), .a0(a0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  // model advances from the inputs presented before the edge, then outputs are sampled 1ns after it
  task automatic tick();
    logic        n_valid, n_ctrl, n_regw, take;
    logic [31:0] n_op1, n_op2;
    logic [4:0]  n_rd;
    n_valid = m_valid; n_ctrl = m_ctrl; n_regw = m_regw; n_op1 = m_op1; n_op2 = m_op2; n_rd = m_rd;
    take = in_valid && (!m_valid || out_ready);
    if (take) begin
      n_valid = 1'b1; n_op1 = m_read(rs1); n_op2 = ALUsrc ? imm : m_read(rs2);
      n_ctrl = ALU_ctrl_in; n_rd = rd; n_regw = RegWrite_in;
    end else if (m_valid && out_ready) n_valid = 1'b0;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 0; m_op1 = 0; m_op2 = 0; m_ctrl = 0; m_rd = 0; m_regw = 0;
    end else begin
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      m_valid = n_valid; m_op1 = n_op1; m_op2 = n_op2; m_ctrl = n_ctrl; m_rd = n_rd; m_regw = n_regw;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, ".a0"}, a0, m_regs[10]);
    if (m_valid) begin
      chk({tag, ".op1"}, op1, m_op1);
      chk({tag, ".op2"}, op2, m_op2);
      chk({tag, ".ctrl"}, {31'd0, ALU_ctrl}, {31'd0, m_ctrl});
      chk({tag, ".rd_q"}, {27'd0, rd_q}, {27'd0, m_rd});
      chk({tag, ".regw"}, {31'd0, RegWrite_q}, {31'd0, m_regw});
    end
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0; rs1 = 0; rs2 = 0; rd = 0;
    imm = 0; ALUsrc = 0; ALU_ctrl_in = 0; RegWrite_in = 0;
  endtask

  initial begin
    // rst in_v ordy alusrc ctrl wb_en rs1 rs2 wb_addr imm wb_data | valid ctrl op1 op2 a0
    vecs[0] = '{0,0,0,0,0,0, 5'd0, 5'd0, 5'd0,  32'h0,        32'h0,   0,0, 32'h0,  32'h0,        32'h0};
    vecs[1] = '{1,0,0,0,0,1, 5'd0, 5'd0, 5'd10, 32'h0,        32'hFF,  0,0, 32'h0,  32'h0,        32'hFF};
    vecs[2] = '{1,1,0,0,0,1, 5'd0, 5'd0, 5'd0,  32'h0,        32'h1234,1,0, 32'h0,  32'h0,        32'hFF};
    vecs[3] = '{1,0,1,0,0,1, 5'd0, 5'd0, 5'd5,  32'h0,        32'h3,   0,0, 32'h0,  32'h0,        32'hFF};
    vecs[4] = '{1,1,1,0,0,1, 5'd5, 5'd0, 5'd5,  32'h0,        32'h7,   1,0, 32'h7,  32'h0,        32'hFF};
    vecs[5] = '{1,1,1,1,0,0, 5'd10,5'd0, 5'd0,  32'hFFFFFFFF, 32'h0,   1,0, 32'hFF, 32'hFFFFFFFF, 32'hFF};
    vecs[6] = '{1,1,1,0,1,0, 5'd5, 5'd10,5'd0,  32'h0,        32'h0,   1,1, 32'h7,  32'hFF,       32'hFF};
    vecs[7] = '{1,0,1,0,0,0, 5'd0, 5'd0, 5'd0,  32'h0,        32'h0,   0,1, 32'h7,  32'hFF,       32'hFF};
    idle();
    rst = 0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].in_valid; out_ready = vecs[i].out_ready;
      ALUsrc = vecs[i].alusrc; ALU_ctrl_in = vecs[i].ctrl; wb_en = vecs[i].wb_en;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; wb_addr = vecs[i].wb_addr;
      imm = vecs[i].imm; wb_data = vecs[i].wb_data;
      tick();
      chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d.a0", i), a0, vecs[i].exp_a0);
      chk($sformatf("vec%0d.op1", i), op1, vecs[i].exp_op1);
      chk($sformatf("vec%0d.op2", i), op2, vecs[i].exp_op2);
      chk($sformatf("vec%0d.ctrl", i), {31'd0, ALU_ctrl}, {31'd0, vecs[i].exp_ctrl});
      if (i == 0) chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    end
    idle();
    // backpressure: A captured, B waits three stalled cycles, then loads
    in_valid = 1; out_ready = 1; ALUsrc = 1; imm = 32'hAAAA; rd = 5'd3; tick();
    chk("bp.A_loaded", op2, 32'hAAAA);
    out_ready = 0; imm = 32'hBBBB; rd = 5'd4; wb_en = 1; wb_addr = 5'd10; wb_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("bp.hold_op2_%0d", i), op2, 32'hAAAA);
      chk($sformatf("bp.hold_rd_%0d", i), {27'd0, rd_q}, 32'd3);
      chk($sformatf("bp.valid%0d", i), {31'd0, out_valid}, 32'd1);
    end
    chk("bp.a0_live", a0, 32'h55);
    wb_en = 0; out_ready = 1; tick();
    chk("bp.B_loaded", op2, 32'hBBBB);
    check_all("bp");
    // back-to-back: four bundles on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      imm = 32'd100 + i; rd = i[4:0]; tick();
      chk($sformatf("b2b.op2_%0d", i), op2, 32'd100 + i);
      chk($sformatf("b2b.valid%0d", i), {31'd0, out_valid}, 32'd1);
    end
    // reset while a bundle is stalled
    out_ready = 0; tick();
    chk("rst_stall.pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 0; tick();
    chk("rst_stall.valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall.op1", op1, 32'd0);
    chk("rst_stall.a0", a0, 32'd0);
    chk("rst_stall.in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1;
    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      in_valid = $urandom_range(0, 1); out_ready = ($urandom_range(0, 3) != 0);
      rs1 = ($urandom_range(0, 4) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom);
      imm = $urandom; ALUsrc = $urandom_range(0, 1);
      ALU_ctrl_in = $urandom_range(0, 1); RegWrite_in = $urandom_range(0, 1);
      wb_en = $urandom_range(0, 1); wb_data = $urandom;
      wb_addr = ($urandom_range(0, 4) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
      tick();
      check_all($sformatf("rnd%0d", n));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
